// File: rtl/grf_writeback_sink.sv
// General register file fed by the W-stage write-back, with bypassed D-stage reads
// and a small trace FIFO that logs every commit for the harness.
module grf_writeback_sink #(
  parameter int DEPTH_LOG2  = 5,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_W,
  input  logic [DEPTH_LOG2-1:0] waddr_W,
  input  logic [31:0]           wdata_W,
  input  logic [31:0]           pc_W,
  input  logic [DEPTH_LOG2-1:0] raddr1_D,
  input  logic [DEPTH_LOG2-1:0] raddr2_D,
  output logic [31:0]           rdata1_D,
  output logic [31:0]           rdata2_D,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [31:0]           trace_pc,
  output logic [DEPTH_LOG2-1:0] trace_reg,
  output logic [31:0]           trace_data,
  output logic                  trace_overflow
);

  localparam int NREGS = 1 << DEPTH_LOG2;
  localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TRACE_DEPTH);

  // Register file; entry 0 is never written and reads are forced to zero anyway.
  logic [31:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_W && (waddr_W != '0)) begin
      regs_q[waddr_W] <= wdata_W;
    end
  end

  // Same-cycle W write is forwarded so D sees the value before it lands.
  always_comb begin
    rdata1_D = regs_q[raddr1_D];
    if (raddr1_D == '0) rdata1_D = '0;
    else if (we_W && (raddr1_D == waddr_W)) rdata1_D = wdata_W;
  end

  always_comb begin
    rdata2_D = regs_q[raddr2_D];
    if (raddr2_D == '0) rdata2_D = '0;
    else if (we_W && (raddr2_D == waddr_W)) rdata2_D = wdata_W;
  end

  // Trace handshake: an entry transfers on a rising edge where trace_valid and
  // trace_ready are both 1; while valid is high and ready low the head holds steady.
  logic [31:0]           tpc_q   [TRACE_DEPTH];
  logic [DEPTH_LOG2-1:0] treg_q  [TRACE_DEPTH];
  logic [31:0]           tdata_q [TRACE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  pop, push;

  always_comb begin
    pop      = (count_q != '0) && trace_ready;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    push     = we_W && ((count_q != FULL_CNT) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (we_W && !push);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        tpc_q[i]   <= '0;
        treg_q[i]  <= '0;
        tdata_q[i] <= '0;
      end
    end else if (push) begin
      tpc_q[wr_ptr_q]   <= pc_W;
      treg_q[wr_ptr_q]  <= waddr_W;
      tdata_q[wr_ptr_q] <= wdata_W;
    end
  end

  assign trace_valid    = (count_q != '0);
  assign trace_pc       = tpc_q[rd_ptr_q];
  assign trace_reg      = treg_q[rd_ptr_q];
  assign trace_data     = tdata_q[rd_ptr_q];
  assign trace_overflow = ovf_q;

endmodule

// File: tb/tb_grf_writeback_sink.sv
// Bench for grf_writeback_sink: directed vector table, hand sequences for the
// FIFO corner cases, then random traffic against a queue-based reference model.
module tb_grf_writeback_sink;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we_W = 1'b0;
  logic [4:0]  waddr_W = '0;
  logic [31:0] wdata_W = '0;
  logic [31:0] pc_W = '0;
  logic [4:0]  raddr1_D = '0;
  logic [4:0]  raddr2_D = '0;
  logic [31:0] rdata1_D, rdata2_D;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_pc;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic        trace_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural registers, expected trace queue {pc,reg,data}.
  logic [31:0] m_regs [32];
  logic [68:0] exp_q[$];
  logic        m_ovf;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        ready;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_valid;
    logic [31:0] e_tpc;
    logic [4:0]  e_treg;
    logic [31:0] e_tdata;
  } vec_t;
  vec_t vecs[7];

  grf_writeback_sink #(.DEPTH_LOG2(5), .TRACE_DEPTH(TD)) dut (
    .clk(clk), .reset(reset), .we_W(we_W), .waddr_W(waddr_W), .wdata_W(wdata_W),
    .pc_W(pc_W), .raddr1_D(raddr1_D), .raddr2_D(raddr2_D), .rdata1_D(rdata1_D),
    .rdata2_D(rdata2_D), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_data(trace_data),
    .trace_overflow(trace_overflow)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic rdy);
    we_W = we; waddr_W = wa; wdata_W = wd; pc_W = pc;
    raddr1_D = ra1; raddr2_D = ra2; trace_ready = rdy;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    exp_q.delete();
    m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we_W && (a == waddr_W)) return wdata_W;
    return m_regs[a];
  endfunction

  task automatic check_model();
    logic [68:0] h;
    chk("rdata1", rdata1_D, model_read(raddr1_D));
    chk("rdata2", rdata2_D, model_read(raddr2_D));
    chk("trace_valid", 32'(trace_valid), 32'(exp_q.size() != 0));
    chk("trace_overflow", 32'(trace_overflow), 32'(m_ovf));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("trace_pc", trace_pc, h[68:37]);
      chk("trace_reg", 32'(trace_reg), 32'(h[36:32]));
      chk("trace_data", trace_data, h[31:0]);
    end
  endtask

  // Model step at the clock edge: drop the head if taken, then enqueue the commit.
  task automatic update_model();
    if (!reset) begin
      clear_model();
      return;
    end
    if ((exp_q.size() != 0) && trace_ready) void'(exp_q.pop_front());
    if (we_W) begin
      if (exp_q.size() < TD) exp_q.push_back({pc_W, waddr_W, wdata_W});
      else m_ovf = 1'b1;
      if (waddr_W != 5'd0) m_regs[waddr_W] = wdata_W;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    tick();
  endtask

  task automatic reset_dut();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    clear_model();
    chk("rst_valid", 32'(trace_valid), 32'h0);
    chk("rst_overflow", 32'(trace_overflow), 32'h0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    clear_model();
    vecs[0] = '{1'b1, 5'd8, 32'h12345678, 32'h100, 5'd8, 5'd0, 1'b0,
                32'h12345678, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd8, 1'b0,
                32'h12345678, 32'h12345678, 1'b1, 32'h100, 5'd8, 32'h12345678};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 32'h104, 5'd0, 5'd8, 1'b0,
                32'h0, 32'h12345678, 1'b1, 32'h100, 5'd8, 32'h12345678};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0,
                32'h0, 32'h0, 1'b1, 32'h100, 5'd8, 32'h12345678};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd0, 1'b1,
                32'h12345678, 32'h0, 1'b1, 32'h100, 5'd8, 32'h12345678};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd8, 1'b1,
                32'h0, 32'h12345678, 1'b1, 32'h104, 5'd0, 32'hFFFFFFFF};
    vecs[6] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd0, 1'b0,
                32'h12345678, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0};

    // Reset, then every address reads zero on both ports
    reset_dut();
    chk("rst_trace_pc", trace_pc, 32'h0);
    chk("rst_trace_reg", 32'(trace_reg), 32'h0);
    chk("rst_trace_data", trace_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      raddr1_D = 5'(a);
      raddr2_D = 5'(31 - a);
      #1;
      chk("rst_read1", rdata1_D, 32'h0);
      chk("rst_read2", rdata2_D, 32'h0);
    end

    // Directed table: bypass, $0 write, trace ordering
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].pc,
            vecs[i].ra1, vecs[i].ra2, vecs[i].ready);
      @(negedge clk);
      chk("tbl_rdata1", rdata1_D, vecs[i].e_rd1);
      chk("tbl_rdata2", rdata2_D, vecs[i].e_rd2);
      chk("tbl_valid", 32'(trace_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk("tbl_trace_pc", trace_pc, vecs[i].e_tpc);
        chk("tbl_trace_reg", 32'(trace_reg), 32'(vecs[i].e_treg));
        chk("tbl_trace_data", trace_data, vecs[i].e_tdata);
      end
      check_model();
      tick();
    end

    // Overflow: five commits into a four-entry FIFO with no consumer
    reset_dut();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'(i), 32'h11 * i, 32'h400 + 4 * i, 5'(i), 5'd0, 1'b0);
      cycle();
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd4, 1'b0);
    @(negedge clk);
    chk("ovf_sticky", 32'(trace_overflow), 32'h1);
    chk("ovf_reg5", rdata1_D, 32'h55);
    chk("ovf_reg4", rdata2_D, 32'h44);
    check_model();
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
      @(negedge clk);
      chk("drain_valid", 32'(trace_valid), 32'h1);
      chk("drain_reg", 32'(trace_reg), 32'(i));
      check_model();
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("drain_empty", 32'(trace_valid), 32'h0);
    tick();

    // Full FIFO with a simultaneous pop and commit
    reset_dut();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'hA0 + i, 32'h800 + 4 * i, 5'd0, 5'd0, 1'b0);
      cycle();
    end
    drive(1'b1, 5'd9, 32'hCAFE0009, 32'h900, 5'd9, 5'd1, 1'b1);
    cycle();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b0);
    @(negedge clk);
    chk("fullpop_ovf", 32'(trace_overflow), 32'h0);
    chk("fullpop_head", 32'(trace_reg), 32'h2);
    chk("fullpop_reg9", rdata1_D, 32'hCAFE0009);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
      @(negedge clk);
      chk("fullpop_drain_valid", 32'(trace_valid), 32'h1);
      chk("fullpop_drain_reg", 32'(trace_reg), (i == 3) ? 32'd9 : 32'(i + 2));
      check_model();
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    cycle();

    // Reset asserted mid-stream with three entries queued
    reset_dut();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), (i == 3) ? 32'd7 : 32'(i + 40), 32'hC00 + 4 * i, 5'd0, 5'd0, 1'b0);
      cycle();
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3, 1'b0);
    @(negedge clk);
    chk("mid_reg3", rdata1_D, 32'd7);
    check_model();
    #2;
    reset = 1'b0;
    #1;
    clear_model();
    chk("mid_valid", 32'(trace_valid), 32'h0);
    chk("mid_reg3_cleared", rdata1_D, 32'h0);
    chk("mid_overflow", 32'(trace_overflow), 32'h0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    cycle();

    // Random traffic; ready is starved in alternate phases to exercise full/overflow
    for (int i = 0; i < 600; i++) begin
      logic rdy;
      if (((i / 40) % 2) == 1) rdy = ($urandom_range(0, 7) == 0);
      else rdy = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rdy);
      if ($urandom_range(0, 3) == 0) raddr2_D = waddr_W;
      cycle();
    end

    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
